// File: rtl/soc_pkg.sv
// SOC-wide timebase constants and bus types, plus the soc_timer register map
// and control-register layout.
package soc_pkg;

  localparam int unsigned PERIOD_PS    = 18519;  // 54 MHz system clock
  localparam int unsigned NUM_1US_CLKS = 53;     // terminal count for a 1 us period

  typedef logic [5:0]  cnt_1us_t;
  typedef logic [31:2] soc_addr_t;
  typedef logic [3:0]  soc_we_t;
  typedef logic [31:0] soc_data_t;

  localparam logic [2:0] TIMER_IDX_CTRL   = 3'd0;
  localparam logic [2:0] TIMER_IDX_COUNT  = 3'd1;
  localparam logic [2:0] TIMER_IDX_CMP    = 3'd2;
  localparam logic [2:0] TIMER_IDX_STATUS = 3'd3;
  localparam logic [2:0] TIMER_IDX_MSCNT  = 3'd4;

  typedef struct packed {
    logic autoreload;
    logic ien;
    logic en;
  } timer_ctrl_t;

  // Replace only the bytes whose write enable is set.
  function automatic soc_data_t byte_merge(soc_data_t old, soc_data_t wdat, soc_we_t we);
    soc_data_t res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = we[i] ? wdat[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_timebase.sv
// Prescaler that divides the system clock down to a one-clock 1 us strobe.
// Reusable by any peripheral that needs a microsecond tick.
module soc_timebase
  import soc_pkg::*;
#(
  parameter cnt_1us_t PRESCALE = cnt_1us_t'(NUM_1US_CLKS)
) (
  input  logic clk,
  input  logic arst,
  input  logic en,
  output logic tick
);

  cnt_1us_t cnt;

  assign tick = en && (cnt == PRESCALE);

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (!en || cnt == PRESCALE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soc_timer.sv
// Memory-mapped microsecond timer with compare interrupt and auto-reload.
// Optional millisecond counter at index 4 when SOC_TIMER_MSCNT_EN is defined.
module soc_timer
  import soc_pkg::*;
#(
  parameter cnt_1us_t  PRESCALE = cnt_1us_t'(NUM_1US_CLKS),
  parameter soc_data_t RST_CMP  = 32'hFFFF_FFFF
) (
  input  logic      clk,
  input  logic      arst,
  input  logic      bus_re,
  input  soc_we_t   bus_we,
  input  soc_addr_t bus_addr,
  input  soc_data_t bus_wdat,
  output soc_data_t bus_rdat,
  output logic      bus_rdy,
  output logic      tick_1us,
  output logic      irq
);

  timer_ctrl_t ctrl;
  soc_data_t   count;
  soc_data_t   cmp;
  logic        pend;
  soc_data_t   rd_val;

  logic [2:0] idx;
  logic       wr;
  logic       match;
  logic       unused_addr;

  assign idx         = bus_addr[4:2];
  assign wr          = |bus_we;
  assign match       = tick_1us && (count == cmp);
  assign irq         = pend & ctrl.ien;
  assign unused_addr = ^bus_addr[31:5];

  soc_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk  (clk),
    .arst (arst),
    .en   (ctrl.en),
    .tick (tick_1us)
  );

  // NOTE: every architectural register has an explicit reset value; there is
  // no memory array here, so nothing is left to power up undefined.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ctrl  <= '0;
      count <= '0;
      cmp   <= RST_CMP;
      pend  <= 1'b0;
    end else begin
      if (wr && idx == TIMER_IDX_CTRL && bus_we[0]) begin
        ctrl <= timer_ctrl_t'(bus_wdat[2:0]);
      end
      // Software write wins over the tick; match still uses the pre-write value.
      if (wr && idx == TIMER_IDX_COUNT) begin
        count <= byte_merge(count, bus_wdat, bus_we);
      end else if (tick_1us) begin
        count <= (match && ctrl.autoreload) ? '0 : count + 1'b1;
      end
      if (wr && idx == TIMER_IDX_CMP) begin
        cmp <= byte_merge(cmp, bus_wdat, bus_we);
      end
      if (match) begin
        pend <= 1'b1;
      end else if (wr && idx == TIMER_IDX_STATUS && bus_we[0] && bus_wdat[0]) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef SOC_TIMER_MSCNT_EN
  logic [9:0] ms_sub;
  soc_data_t  mscnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ms_sub <= '0;
      mscnt  <= '0;
    end else begin
      if (tick_1us) begin
        ms_sub <= (ms_sub == 10'd999) ? '0 : ms_sub + 1'b1;
      end
      if (wr && idx == TIMER_IDX_MSCNT) begin
        mscnt <= byte_merge(mscnt, bus_wdat, bus_we);
      end else if (tick_1us && ms_sub == 10'd999) begin
        mscnt <= mscnt + 1'b1;
      end
    end
  end
`endif

  // NOTE: rd_val gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    rd_val = '0;
    case (idx)
      TIMER_IDX_CTRL:   rd_val = {29'd0, ctrl};
      TIMER_IDX_COUNT:  rd_val = count;
      TIMER_IDX_CMP:    rd_val = cmp;
      TIMER_IDX_STATUS: rd_val = {31'd0, pend};
`ifdef SOC_TIMER_MSCNT_EN
      TIMER_IDX_MSCNT:  rd_val = mscnt;
`endif
      default:          rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bus_rdy  <= 1'b0;
      bus_rdat <= '0;
    end else begin
      bus_rdy  <= bus_re | wr;
      bus_rdat <= bus_re ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_soc_timer.sv
// Directed self-checking bench for soc_timer with hand-computed expectations.
// Covers SOC_TIMER_MSCNT_EN paths when that macro is defined.
module tb_soc_timer;
  import soc_pkg::*;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        bus_re = 1'b0;
  logic [3:0]  bus_we = 4'h0;
  logic [31:2] bus_addr = '0;
  logic [31:0] bus_wdat = '0;
  logic [31:0] bus_rdat;
  logic        bus_rdy;
  logic        tick_1us;
  logic        irq;

  int checks = 0;
  int errors = 0;

  soc_timer dut (
    .clk      (clk),
    .arst     (arst),
    .bus_re   (bus_re),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdat (bus_wdat),
    .bus_rdat (bus_rdat),
    .bus_rdy  (bus_rdy),
    .tick_1us (tick_1us),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] we);
    @(negedge clk);
    bus_addr = {27'd0, idx};
    bus_wdat = data;
    bus_we   = we;
    @(negedge clk);
    bus_we   = 4'h0;
    check("wr_rdy", {31'd0, bus_rdy}, 32'd1);
    check("wr_rdat_zero", bus_rdat, 32'd0);
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [31:0] data);
    @(negedge clk);
    bus_addr = {27'd0, idx};
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re   = 1'b0;
    check("rd_rdy", {31'd0, bus_rdy}, 32'd1);
    data = bus_rdat;
  endtask

  task automatic read_check(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(idx, d);
    check(tag, d, exp);
  endtask

  // Returns at the negedge where tick_1us is high; flags a timeout otherwise.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tick_1us) seen = 1'b1;
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #23;
    arst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int n;
    bit seen;
    int exp_cnt[6] = '{1, 2, 0, 1, 2, 0};

    do_reset();
    @(negedge clk);
    check("rst_rdy", {31'd0, bus_rdy}, 32'd0);
    check("rst_rdat", bus_rdat, 32'd0);
    check("rst_tick", {31'd0, tick_1us}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      bus_read(3'(i), d);
      check($sformatf("rst_idx%0d", i), d, (i == 2) ? 32'hFFFF_FFFF : 32'd0);
      @(negedge clk);
      check("rdy_one_cycle", {31'd0, bus_rdy}, 32'd0);
    end

    // Register access with the timer disabled.
    bus_write(TIMER_IDX_CTRL, 32'hFFFF_FFFF, 4'hF);
    read_check("ctrl_bits", TIMER_IDX_CTRL, 32'd7);
    bus_write(TIMER_IDX_CTRL, 32'd0, 4'hF);
    bus_write(TIMER_IDX_CMP, 32'h0000_AB00, 4'b0010);
    read_check("cmp_byte", TIMER_IDX_CMP, 32'hFFFF_ABFF);
    bus_write(TIMER_IDX_COUNT, 32'h1234_5678, 4'b1000);
    read_check("count_byte", TIMER_IDX_COUNT, 32'h1200_0000);
    bus_write(3'd6, 32'hDEAD_BEEF, 4'hF);
    read_check("idx6_zero", 3'd6, 32'd0);
    bus_write(TIMER_IDX_COUNT, 32'h11, 4'hF);
    @(negedge clk);
    bus_addr = {27'd0, TIMER_IDX_COUNT};
    bus_wdat = 32'h55;
    bus_we   = 4'hF;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_we   = 4'h0;
    bus_re   = 1'b0;
    check("rw_old_value", bus_rdat, 32'h11);
    read_check("rw_new_value", TIMER_IDX_COUNT, 32'h55);
    check("tick_off", {31'd0, tick_1us}, 32'd0);

    // Free-running count: 540 enabled clocks give exactly 10 ticks.
    bus_write(TIMER_IDX_COUNT, 32'd0, 4'hF);
    bus_write(TIMER_IDX_CTRL, 32'd1, 4'hF);
    repeat (539) @(negedge clk);
    read_check("count_540", TIMER_IDX_COUNT, 32'd10);
    wait_tick();
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (tick_1us) seen = 1'b1;
    end
    check("tick_period", 32'(n), 32'd54);

    // One-shot compare with interrupt.
    bus_write(TIMER_IDX_CTRL, 32'd0, 4'hF);
    bus_write(TIMER_IDX_COUNT, 32'd0, 4'hF);
    bus_write(TIMER_IDX_STATUS, 32'd1, 4'hF);
    bus_write(TIMER_IDX_CMP, 32'd5, 4'hF);
    bus_write(TIMER_IDX_CTRL, 32'd3, 4'hF);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
      else if (tick_1us) n++;
    end
    check("irq_seen", {31'd0, seen}, 32'd1);
    check("irq_after_6_ticks", 32'(n), 32'd6);
    read_check("count_after_match", TIMER_IDX_COUNT, 32'd6);
    bus_write(TIMER_IDX_STATUS, 32'd1, 4'b0001);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    read_check("pend_cleared", TIMER_IDX_STATUS, 32'd0);

    // Periodic mode with autoreload.
    bus_write(TIMER_IDX_CTRL, 32'd0, 4'hF);
    bus_write(TIMER_IDX_COUNT, 32'd0, 4'hF);
    bus_write(TIMER_IDX_CMP, 32'd2, 4'hF);
    bus_write(TIMER_IDX_CTRL, 32'd7, 4'hF);
    for (int t = 0; t < 6; t++) begin
      wait_tick();
      if (t == 5) begin
        // W1C lands in the same cycle as the matching tick.
        bus_addr = {27'd0, TIMER_IDX_STATUS};
        bus_wdat = 32'd1;
        bus_we   = 4'h1;
        @(negedge clk);
        bus_we   = 4'h0;
        check("w1c_vs_match_irq", {31'd0, irq}, 32'd1);
      end
      read_check($sformatf("reload_seq%0d", t), TIMER_IDX_COUNT, 32'(exp_cnt[t]));
      if (t == 1) check("no_pend_early", {31'd0, irq}, 32'd0);
      if (t == 2) begin
        check("pend_on_3rd", {31'd0, irq}, 32'd1);
        bus_write(TIMER_IDX_STATUS, 32'd1, 4'h1);
        check("w1c_clear", {31'd0, irq}, 32'd0);
      end
    end
    read_check("pend_kept", TIMER_IDX_STATUS, 32'd1);

    // Wrap from FFFF_FFFF to 0 without a flag, then match at 0.
    bus_write(TIMER_IDX_CTRL, 32'd0, 4'hF);
    bus_write(TIMER_IDX_COUNT, 32'hFFFF_FFFE, 4'hF);
    bus_write(TIMER_IDX_CMP, 32'd0, 4'hF);
    bus_write(TIMER_IDX_STATUS, 32'd1, 4'hF);
    bus_write(TIMER_IDX_CTRL, 32'd1, 4'hF);
    wait_tick();
    read_check("wrap_ff", TIMER_IDX_COUNT, 32'hFFFF_FFFF);
    read_check("wrap_ff_nopend", TIMER_IDX_STATUS, 32'd0);
    wait_tick();
    read_check("wrap_zero", TIMER_IDX_COUNT, 32'd0);
    read_check("wrap_zero_nopend", TIMER_IDX_STATUS, 32'd0);
    wait_tick();
    read_check("match_zero_pend", TIMER_IDX_STATUS, 32'd1);
    read_check("match_zero_count", TIMER_IDX_COUNT, 32'd1);
    check("irq_masked", {31'd0, irq}, 32'd0);

`ifdef SOC_TIMER_MSCNT_EN
    do_reset();
    bus_write(TIMER_IDX_CTRL, 32'd1, 4'hF);
    for (int t = 0; t < 1000; t++) wait_tick();
    read_check("mscnt_one", TIMER_IDX_MSCNT, 32'd1);
    read_check("count_1000", TIMER_IDX_COUNT, 32'd1000);
    bus_write(TIMER_IDX_MSCNT, 32'h0000_0042, 4'hF);
    read_check("mscnt_rw", TIMER_IDX_MSCNT, 32'h42);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/soc_timer.md
Name: soc_timer

Overview:
- Memory-mapped microsecond timer on the SOC data bus; directly downstream of the SOC-wide timebase constants (PERIOD_PS, NUM_1US_CLKS, cnt_1us_t).
- Prescales the system clock to a 1 us strobe, keeps a 32-bit microsecond counter, and compares it against a software compare value.
- Raises a level interrupt to the CPU on match; optional auto-reload gives a periodic tick for firmware scheduling.

Parameters:
- PRESCALE, default soc_pkg::NUM_1US_CLKS (53 at 54 MHz), terminal value of the prescaler; the prescaler period is PRESCALE+1 clocks.
- RST_CMP, default 32'hFFFF_FFFF, reset value of the CMP register.

Ports:
- clk  in  1  system clock, single domain.
- arst  in  1  asynchronous, active-high reset.
- bus_re  in  1  read strobe, one cycle.
- bus_we  in  soc_we_t (4)  per-byte write enables; nonzero means a write.
- bus_addr  in  soc_addr_t ([31:2])  word address; bits [4:2] select the register.
- bus_wdat  in  soc_data_t (32)  write data.
- bus_rdat  out  soc_data_t (32)  read data, valid while bus_rdy=1.
- bus_rdy  out  1  access-complete pulse.
- tick_1us  out  1  one-clock strobe every PRESCALE+1 clocks while enabled.
- irq  out  1  level interrupt, equal to STATUS.pend & CTRL.ien.

Behaviour:
- Reset state: all outputs 0, prescaler 0, COUNT=0, CTRL=0, CMP=RST_CMP, pend=0. Reset is asynchronous; on release the timer is idle and disabled.
- Register map (word index = bus_addr[4:2]):
  - 0 CTRL: [0] en, [1] ien, [2] autoreload. Other bits read as 0.
  - 1 COUNT: R/W.
  - 2 CMP: R/W.
  - 3 STATUS: [0] pend, write-1-to-clear.
  - Other indexes read 0 and ignore writes.
- Bus access:
  - bus_rdy pulses exactly 1 clock after any cycle with bus_re=1 or bus_we!=0.
  - bus_rdat is registered on that same cycle; it is 0 whenever bus_rdy=0.
  - Writes honour each byte enable independently (CTRL, COUNT, CMP).
  - If re and we are asserted together, the write executes and the read returns the pre-write value.
- Prescaler (cnt_1us_t width):
  - Counts only while en=1.
  - At PRESCALE it wraps to 0 and asserts tick_1us for that cycle.
  - en=0 holds the prescaler at 0 on the next clock and forces tick_1us=0.
- Counter, on tick_1us:
  - If COUNT==CMP: set pend; then load 0 if autoreload=1, else COUNT+1.
  - Otherwise COUNT+1.
  - 32'hFFFF_FFFF wraps to 0 with no flag.
- Priority and simultaneous events:
  - A software write to COUNT beats the tick increment in the same cycle; the match is still evaluated on the pre-write value.
  - A hardware set of pend beats a W1C in the same cycle.
  - Writing CMP does not affect pend.
  - A match is detected only on a tick edge. Writing COUNT equal to CMP does not set pend until the next matching tick.
- Latency: pend and irq rise 1 clock after the tick cycle that matched.

Optional Feature:
- Macro: SOC_TIMER_MSCNT_EN.
- When defined:
  - Adds a millisecond sub-counter that counts ticks 0..999.
  - Adds a 32-bit MSCNT register at index 4, incremented when the sub-counter wraps.
  - MSCNT is R/W; it resets to 0 and wraps silently.
- When undefined: index 4 reads 0, and the sub-counter and MSCNT logic are absent.

Decomposition:
- soc_pkg additions:
  - TIMER_IDX_CTRL/COUNT/CMP/STATUS/MSCNT constants.
  - timer_ctrl_t packed struct {autoreload, ien, en}.
- Existing soc_pkg types reused: cnt_1us_t, soc_addr_t, soc_we_t, soc_data_t.
- Sub-module: soc_timebase, containing the prescaler plus the tick_1us output. It is reusable by other peripherals needing a 1 us strobe.

Test Plan:
- Reset, then read each index 0..5 -> bus_rdy 1 clock after each re; data 0,0,0,0,0(,0) except CMP=FFFF_FFFF.
- Write CTRL=1 -> tick_1us period is exactly 54 clocks; COUNT=10 after 540 clocks (±1 for the write cycle).
- Write CMP=5, CTRL=3 -> irq rises 1 clock after the 6th tick; COUNT=6 since autoreload=0; W1C STATUS=1 clears irq.
- CTRL=7, CMP=2 -> pend on every 3rd tick, COUNT sequence 0,1,2,0,1,2; W1C in the same cycle as a match leaves pend=1.
- Write COUNT=FFFF_FFFE, CMP=0, en=1 -> COUNT goes FFFF_FFFF then 0, no pend; the following tick matches 0 and sets pend.
- Byte write bus_we=4'b0010, wdat=0000_AB00 to CMP=FFFF_FFFF -> CMP=FFFF_ABFF. With SOC_TIMER_MSCNT_EN, after 1000 ticks -> MSCNT=1.
